ad_ip_jesd204_tpl_adc_capture_ctrl: RTL and testbench

//  Triggered capture sequencer between the TPL ADC core sample output and the DMA write port, in the link_clk domain.

---
 rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Triggered capture sequencer between the TPL ADC core and the DMA write port.
// Software arms a capture. The block then waits for a trigger, drops a
// programmable number of valid beats, forwards exactly cfg_length beats to the
// DMA and goes back to idle.
//
// Ports:
//   clk, resetn        link_clk, asynchronous active-low reset
//   cfg_arm/cfg_abort  single-cycle control pulses from the regmap
//   cfg_trig_mode      0 immediate, 1 rising, 2 falling, 3 level-high ext_trig
//   cfg_delay/length   beats to discard after the trigger / beats to forward
//   ext_trig           trigger input, already synchronous to clk
//   adc_valid_in/data  sample stream from the TPL core
//   dma_dovf           DMA overflow indication
//   dma_valid/data     registered, gated stream to the DMA
//   dma_sync           marks the first forwarded beat of a capture
//   status_*           busy, done pulse, sticky overflow and current state
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_arm,
    input  logic                    cfg_abort,
    input  logic [1:0]              cfg_trig_mode,
    input  logic [COUNT_WIDTH-1:0]  cfg_delay,
    input  logic [COUNT_WIDTH-1:0]  cfg_length,
    input  logic                    ext_trig,
    input  logic [NUM_CHANNELS-1:0] adc_valid_in,
    input  logic [DATA_WIDTH-1:0]   adc_data_in,
    input  logic                    dma_dovf,
    output logic [NUM_CHANNELS-1:0] dma_valid,
    output logic [DATA_WIDTH-1:0]   dma_data,
    output logic                    dma_sync,
    output logic                    status_busy,
    output logic                    status_done,
    output logic                    status_ovf,
    output logic [1:0]              status_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DELAY   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_nxt;
    logic [COUNT_WIDTH-1:0] delay_q;
    logic [COUNT_WIDTH-1:0] delay_nxt;
    logic [COUNT_WIDTH-1:0] length_q;
    logic [COUNT_WIDTH-1:0] length_nxt;
    logic [1:0]             mode_q;
    logic [1:0]             mode_nxt;
    logic                   trig_d;
    logic                   beat;
    logic                   trig;
    logic                   arm_ok;
    logic                   fwd_nxt;
    logic                   sync_nxt;
    logic                   done_nxt;
    logic                   ovf_nxt;

    assign beat   = |adc_valid_in;
    assign arm_ok = cfg_arm && !cfg_abort && (cfg_length != '0);

    // Trigger qualification against the latched mode; edges use the previous ext_trig.
    always_comb begin
        trig = 1'b0;
        case (mode_q)
            2'd0:    trig = 1'b1;
            2'd1:    trig = ext_trig & ~trig_d;
            2'd2:    trig = ~ext_trig & trig_d;
            default: trig = ext_trig;
        endcase
    end

    // Next-state, counter and output decode; abort overrides every state.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        delay_nxt  = delay_q;
        length_nxt = length_q;
        mode_nxt   = mode_q;
        fwd_nxt    = 1'b0;
        sync_nxt   = 1'b0;
        done_nxt   = 1'b0;
        ovf_nxt    = status_ovf | (dma_dovf && (state == ST_CAPTURE));

        if (cfg_abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_ok) begin
                        delay_nxt  = cfg_delay;
                        length_nxt = cfg_length;
                        mode_nxt   = cfg_trig_mode;
                        cnt_nxt    = '0;
                        ovf_nxt    = 1'b0;
                        state_nxt  = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Beats in the trigger-detect cycle are discarded.
                    if (trig) begin
                        cnt_nxt   = '0;
                        state_nxt = (delay_q != '0) ? ST_DELAY : ST_CAPTURE;
                    end
                end
                ST_DELAY: begin
                    if (beat) begin
                        if (cnt == delay_q - COUNT_WIDTH'(1)) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_CAPTURE;
                        end else begin
                            cnt_nxt = cnt + COUNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    fwd_nxt = 1'b1;
                    if (beat) begin
                        sync_nxt = (cnt == '0);
                        if (cnt == length_q - COUNT_WIDTH'(1)) begin
                            done_nxt  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt = cnt + COUNT_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            delay_q      <= '0;
            length_q     <= '0;
            mode_q       <= 2'd0;
            trig_d       <= 1'b0;
            dma_valid    <= '0;
            dma_data     <= '0;
            dma_sync     <= 1'b0;
            status_busy  <= 1'b0;
            status_done  <= 1'b0;
            status_ovf   <= 1'b0;
            status_state <= 2'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            delay_q      <= delay_nxt;
            length_q     <= length_nxt;
            mode_q       <= mode_nxt;
            trig_d       <= ext_trig;
            dma_valid    <= fwd_nxt ? adc_valid_in : '0;
            dma_data     <= adc_data_in;
            dma_sync     <= sync_nxt;
            status_busy  <= (state_nxt != ST_IDLE);
            status_done  <= done_nxt;
            status_ovf   <= ovf_nxt;
            status_state <= 2'(state_nxt);
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Scoreboard bench for the capture sequencer. A stimulus trace is built up
// front: directed scenarios first, then random traffic. An episode-level model
// walks the trace (arm -> trigger -> delay beats -> length beats, with aborts)
// and queues the expected DMA beats. A monitor pops the queue and compares it
// against every output the DUT presents.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 128;
    localparam int unsigned CW  = 32;
    localparam int          N   = 3000;

    logic           clk = 1'b0;
    logic           resetn;
    logic           cfg_arm, cfg_abort, ext_trig, dma_dovf;
    logic [1:0]     cfg_trig_mode;
    logic [CW-1:0]  cfg_delay, cfg_length;
    logic [NCH-1:0] adc_valid_in;
    logic [DW-1:0]  adc_data_in;
    logic [NCH-1:0] dma_valid;
    logic [DW-1:0]  dma_data;
    logic           dma_sync, status_busy, status_done, status_ovf;
    logic [1:0]     status_state;

    ad_ip_jesd204_tpl_adc_capture_ctrl #(
        .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_trig_mode(cfg_trig_mode), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .ext_trig(ext_trig), .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
        .dma_dovf(dma_dovf), .dma_valid(dma_valid), .dma_data(dma_data),
        .dma_sync(dma_sync), .status_busy(status_busy), .status_done(status_done),
        .status_ovf(status_ovf), .status_state(status_state)
    );

    always #5 clk = ~clk;

    // Stimulus trace, one entry per clock edge.
    logic           t_arm [N];
    logic           t_abort [N];
    logic [1:0]     t_mode [N];
    int             t_delay [N];
    int             t_len [N];
    logic           t_trig [N];
    logic [NCH-1:0] t_valid [N];
    logic [DW-1:0]  t_data [N];
    logic           t_dovf [N];

    // Expected state during each cycle, accepted arms, and sticky overflow after each edge.
    int   e_st [N+1];
    logic e_acc [N];
    logic e_ovf [N];

    typedef struct {
        int             edge_i;
        logic [NCH-1:0] v;
        logic [DW-1:0]  d;
        logic           s;
        logic           dn;
    } rec_t;
    rec_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int edge_idx = 0;
    logic mon_en = 1'b0;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, req, edge_idx);
    endfunction

    function automatic logic trig_at(logic [1:0] m, int c);
        logic prev;
        prev = (c == 0) ? 1'b0 : t_trig[c-1];
        case (m)
            2'd0:    return 1'b1;
            2'd1:    return t_trig[c] & ~prev;
            2'd2:    return ~t_trig[c] & prev;
            default: return t_trig[c];
        endcase
    endfunction

    task automatic gen_trace();
        logic lvl;
        lvl = 1'b0;
        for (int c = 0; c < N; c++) begin
            t_arm[c]   = ($urandom_range(0, 99) < 4);
            t_abort[c] = ($urandom_range(0, 199) == 0);
            t_mode[c]  = 2'($urandom_range(0, 3));
            t_delay[c] = int'($urandom_range(0, 5));
            t_len[c]   = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) lvl = ~lvl;
            t_trig[c]  = lvl;
            t_valid[c] = ($urandom_range(0, 2) == 0) ? '0 : NCH'($urandom_range(1, 15));
            t_data[c]  = {$urandom, $urandom, $urandom, $urandom};
            t_dovf[c]  = ($urandom_range(0, 49) == 0);
        end
        for (int c = 0; c < 200; c++) begin
            t_arm[c] = 1'b0; t_abort[c] = 1'b0; t_dovf[c] = 1'b0;
            t_trig[c] = 1'b0; t_valid[c] = '1;
        end
        // Immediate trigger, no delay, four beats.
        t_arm[2] = 1'b1; t_mode[2] = 2'd0; t_delay[2] = 0; t_len[2] = 4;
        // Rising edge at 30, three beats dropped, two forwarded.
        t_arm[20] = 1'b1; t_mode[20] = 2'd1; t_delay[20] = 3; t_len[20] = 2;
        for (int c = 30; c < 50; c++) t_trig[c] = 1'b1;
        // Rising edge with gapped valid: three beats, gaps kept.
        t_arm[60] = 1'b1; t_mode[60] = 2'd1; t_delay[60] = 0; t_len[60] = 3;
        for (int c = 60; c <= 80; c++) t_valid[c] = (c % 2 == 0) ? '1 : '0;
        for (int c = 65; c <= 85; c++) t_trig[c] = 1'b1;
        // Abort after two of eight beats.
        t_arm[90] = 1'b1; t_mode[90] = 2'd0; t_delay[90] = 0; t_len[90] = 8;
        t_abort[94] = 1'b1;
        // Arm together with abort, then arm with zero length, then overflow while idle.
        t_arm[110] = 1'b1; t_abort[110] = 1'b1; t_mode[110] = 2'd0; t_len[110] = 5;
        t_arm[115] = 1'b1; t_mode[115] = 2'd0; t_len[115] = 0;
        t_dovf[120] = 1'b1;
        // Overflow inside a capture stays sticky until the next accepted arm.
        t_arm[130] = 1'b1; t_mode[130] = 2'd0; t_delay[130] = 0; t_len[130] = 6;
        t_dovf[134] = 1'b1; t_dovf[145] = 1'b1;
        // Level trigger with delay, then falling-edge trigger.
        t_arm[160] = 1'b1; t_mode[160] = 2'd3; t_delay[160] = 2; t_len[160] = 3;
        for (int c = 158; c < 180; c++) t_trig[c] = 1'b1;
        t_arm[175] = 1'b1; t_mode[175] = 2'd2; t_delay[175] = 1; t_len[175] = 2;
    endtask

    // Episode-level reference: find accepted arm, trigger, skip delay beats, take length beats.
    task automatic build_model();
        int t, c, k, seen, n, d, l;
        logic [1:0] m;
        logic aborted, ovf;
        for (int i = 0; i <= N; i++) e_st[i] = 0;
        for (int i = 0; i < N; i++) e_acc[i] = 1'b0;
        t = 0;
        while (t < N) begin
            if (!(t_arm[t] && !t_abort[t] && t_len[t] != 0)) begin
                t++;
                continue;
            end
            e_acc[t] = 1'b1;
            m = t_mode[t]; d = t_delay[t]; l = t_len[t];
            aborted = 1'b0;
            c = t + 1;
            while (c < N) begin
                e_st[c] = 1;
                if (t_abort[c]) begin aborted = 1'b1; break; end
                if (trig_at(m, c)) break;
                c++;
            end
            if (c >= N) break;
            if (aborted) begin t = c + 1; continue; end
            k = c + 1; seen = 0;
            while (k < N && seen < d) begin
                e_st[k] = 2;
                if (t_abort[k]) begin aborted = 1'b1; break; end
                if (t_valid[k] != '0) seen++;
                k++;
            end
            if (aborted) begin t = k + 1; continue; end
            n = 0;
            while (k < N) begin
                e_st[k] = 3;
                if (t_abort[k]) break;
                if (t_valid[k] != '0) begin
                    exp_q.push_back('{edge_i: k, v: t_valid[k], d: t_data[k],
                                      s: (n == 0), dn: (n == l - 1)});
                    n++;
                    if (n == l) break;
                end
                k++;
            end
            t = k + 1;
        end
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (e_acc[i]) ovf = 1'b0;
            if (t_dovf[i] && e_st[i] == 3) ovf = 1'b1;
            e_ovf[i] = ovf;
        end
    endtask

    task automatic drive(int c);
        cfg_arm       = t_arm[c];
        cfg_abort     = t_abort[c];
        cfg_trig_mode = t_mode[c];
        cfg_delay     = CW'(t_delay[c]);
        cfg_length    = CW'(t_len[c]);
        ext_trig      = t_trig[c];
        adc_valid_in  = t_valid[c];
        adc_data_in   = t_data[c];
        dma_dovf      = t_dovf[c];
    endtask

    task automatic drive_idle();
        cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_trig_mode = 2'd0;
        cfg_delay = '0; cfg_length = '0; ext_trig = 1'b0;
        adc_valid_in = '0; adc_data_in = '0; dma_dovf = 1'b0;
    endtask

    // Monitor: outputs from edge edge_idx are sampled on the following falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (edge_idx + 1 < N) begin
                chk("status_state", DW'(status_state), DW'(e_st[edge_idx+1]));
                chk("status_busy", DW'(status_busy), DW'(e_st[edge_idx+1] != 0));
            end
            chk("status_ovf", DW'(status_ovf), DW'(e_ovf[edge_idx]));
            if (exp_q.size() != 0 && exp_q[0].edge_i == edge_idx) begin
                rec_t r;
                r = exp_q.pop_front();
                chk("dma_valid", DW'(dma_valid), DW'(r.v));
                if (dma_valid != '0) chk("dma_data", dma_data, r.d);
                chk("dma_sync", DW'(dma_sync), DW'(r.s));
                chk("status_done", DW'(status_done), DW'(r.dn));
            end else begin
                chk("idle_outputs", DW'({dma_sync, status_done, dma_valid}), '0);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        drive_idle();
        gen_trace();
        build_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", DW'(dma_valid), '0);
        chk("reset_flags", DW'({dma_sync, status_busy, status_done, status_ovf}), '0);
        chk("reset_state", DW'(status_state), '0);
        resetn = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < N; c++) begin
            drive(c);
            @(posedge clk);
            edge_idx = c;
            #1;
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("leftover_expected", DW'(exp_q.size()), '0);

        // Asynchronous reset in the middle of a long capture.
        drive_idle();
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        cfg_arm = 1'b1; cfg_length = CW'(100); adc_valid_in = '1;
        @(posedge clk); #1;
        cfg_arm = 1'b0; cfg_length = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_valid", DW'(dma_valid), DW'(4'hF));
        chk("pre_reset_busy", DW'(status_busy), DW'(1));
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_valid", DW'(dma_valid), '0);
        chk("async_reset_flags", DW'({dma_sync, status_busy, status_done}), '0);
        chk("async_reset_state", DW'(status_state), '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_reset_quiet", DW'({status_done, status_busy, dma_valid}), '0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
